vertex_sequencer: RTL
=====================

// Module: vertex_sequencer
// PURPOSE
//  Sequences one draw batch through vertex_shader. On start it loads the 4x4 transform into the
//  shader one column per cycle. It then streams vertex_count xyz vertices from a vertex BRAM into
//  the shader with fixed read latency, and counts shader outputs to signal batch completion.
//  Sits between the frame controller (start/done) and vertex_shader (col_set/col/valid/vertex).
// PARAMETERS
//  ADDR_WIDTH   12  vertex BRAM address width; addresses wrap modulo 2**ADDR_WIDTH
//  COUNT_WIDTH  12  width of vertex count and internal issue/complete counters
//  MEM_LATENCY  2   cycles from mem_addr_out/mem_en_out registered to vertex_data_in valid (>=1)
// PORTS
//  clk_in          in   1        system clock
//  rst_in          in   1        reset, asynchronous, active-high
//  start_in        in   1        begin batch; sampled only in IDLE
//  matrix_in       in   [3:0][3:0][31:0]  fp32 matrix, [col][w,z,y,x]; latched on accepted start
//  base_addr_in    in   ADDR_WIDTH   first vertex address; latched on accepted start
//  count_in        in   COUNT_WIDTH  vertices in batch; latched on accepted start
//  busy_out        out  1        high in every state except IDLE
//  done_out        out  1        1-cycle pulse when batch fully through shader
//  mem_en_out      out  1        BRAM read enable
//  mem_addr_out    out  ADDR_WIDTH   BRAM read address
//  vertex_data_in  in   [2:0][31:0]  BRAM read data {z,y,x}
//  col_set_out     out  1        to shader col_set_in
//  col_out         out  [3:0][31:0]  to shader col_in
//  valid_out       out  1        to shader valid_in
//  vertex_out      out  [2:0][31:0]  to shader vertex_in
//  shader_valid_in in   1        from shader valid_out; one per completed vertex
// BEHAVIOUR
//  - All outputs registered. Reset (async, any time) -> state IDLE, all outputs 0, counters 0.
//    The latency pipe is cleared; in-flight shader results after reset are ignored.
//  - States: IDLE -> LOAD -> FETCH -> DRAIN -> IDLE. DONE is the done_out pulse on DRAIN exit.
//  - IDLE: start_in=1 at edge T latches matrix/base/count and enters LOAD. start_in outside IDLE
//    is ignored (no queueing).
//  - LOAD: cycles T+1..T+4, col_set_out=1, col_out = column 0,1,2,3 in order; then FETCH.
//  - FETCH: each cycle asserts mem_en_out=1 with mem_addr_out = base+i for i=0..count-1.
//    Issue rate is one per cycle, so the first address is at T+5. Issue flag is delayed MEM_LATENCY cycles.
//    Delayed flag drives valid_out=1, vertex_out=vertex_data_in (same cycle the data is valid).
//    After the last issue, mem_en_out=0 and the state moves to DRAIN.
//  - count_in=0: LOAD still runs (matrix updated), FETCH issues nothing, done_out pulses at T+5.
//  - DRAIN: counts shader_valid_in pulses. shader_valid_in is counted in any non-IDLE state,
//    including during FETCH. When completed == count, done_out=1 for one cycle, then IDLE.
//    No timeout; the shader latency is fixed.
//  - shader_valid_in in IDLE is ignored. col_set_out is never high while a vertex is in flight
//    (a new LOAD only follows done).
//  - No backpressure: downstream must accept one vertex per cycle.
//  - Counters are COUNT_WIDTH bits; max batch = 2**COUNT_WIDTH-1. Address add truncates (wraps).
// TESTING
//  1. Reset then start with matrix cols {40C00000,3F800000,40000000,41100000},{40400000,0,41100000,
//     40C00000},{3F800000,40400000,3F800000,40A00000},{3F800000,40A00000,40E00000,0}
//     -> col_set_out high exactly 4 cycles, columns in that order, busy_out=1.
//  2. base=0x010, count=3, BRAM preloaded -> mem_addr 010,011,012 on consecutive cycles;
//     valid_out 3 cycles starting MEM_LATENCY later with matching data;
//     done_out single pulse after the 3rd shader_valid_in.
//     Vertex {40800000,3F800000,40A00000} through real shader -> shader output matches golden.
//  3. count=0 -> 4-cycle LOAD, no mem_en_out, no valid_out, done_out at T+5, back to IDLE.
//  4. base=0xFFE, count=4 -> addresses FFE,FFF,000,001; done after 4 completions.
//  5. start_in pulsed during FETCH and DRAIN -> ignored; then back-to-back batches with start
//     the cycle after done -> second LOAD begins cleanly.
//  6. rst_in asserted mid-FETCH (between edges) -> outputs 0 immediately, IDLE, no done_out;
//     a following batch completes with correct counts.

Source files
------------

// File: rtl/vertex_sequencer_if.sv
// vertex_sequencer_if: frame-controller, vertex BRAM and shader signals of one vertex_sequencer
interface vertex_sequencer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int COUNT_WIDTH = 12
);
  logic start_in;
  logic [3:0][3:0][31:0] matrix_in;
  logic [ADDR_WIDTH-1:0] base_addr_in;
  logic [COUNT_WIDTH-1:0] count_in;
  logic busy_out;
  logic done_out;
  logic mem_en_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [2:0][31:0] vertex_data_in;
  logic col_set_out;
  logic [3:0][31:0] col_out;
  logic valid_out;
  logic [2:0][31:0] vertex_out;
  logic shader_valid_in;
  modport master (
    input start_in, matrix_in, base_addr_in, count_in, vertex_data_in, shader_valid_in,
    output busy_out, done_out, mem_en_out, mem_addr_out, col_set_out, col_out, valid_out, vertex_out
  );
  modport slave (
    output start_in, matrix_in, base_addr_in, count_in, vertex_data_in, shader_valid_in,
    input busy_out, done_out, mem_en_out, mem_addr_out, col_set_out, col_out, valid_out, vertex_out
  );
endinterface

// File: rtl/vertex_sequencer.sv
// vertex_sequencer: loads a 4x4 transform into vertex_shader, streams a vertex batch from BRAM, counts results
module vertex_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int COUNT_WIDTH = 12,
  parameter int MEM_LATENCY = 2
) (
  input logic clk_in,
  input logic rst_in,
  vertex_sequencer_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FETCH = 2'd2, DRAIN = 2'd3;
  logic [1:0] state, col_idx;
  logic [3:0][3:0][31:0] mat;
  logic [ADDR_WIDTH-1:0] base;
  logic [COUNT_WIDTH-1:0] count, issued, completed, completed_nxt;
  logic [MEM_LATENCY-1:0] pipe;
  logic issue;
  // issue is the next value of mem_en_out; pipe delays it so its top bit lines up with BRAM data
  always_comb begin
    issue = (state == LOAD && col_idx == 2'd3 && count != '0) || (state == FETCH && issued != count);
    completed_nxt = completed + COUNT_WIDTH'(bus.shader_valid_in);
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      col_idx <= '0;
      mat <= '0;
      base <= '0;
      count <= '0;
      issued <= '0;
      completed <= '0;
      pipe <= '0;
      bus.busy_out <= 1'b0;
      bus.done_out <= 1'b0;
      bus.mem_en_out <= 1'b0;
      bus.mem_addr_out <= '0;
      bus.col_set_out <= 1'b0;
      bus.col_out <= '0;
      bus.valid_out <= 1'b0;
      bus.vertex_out <= '0;
    end else begin
      bus.done_out <= 1'b0;
      pipe <= (pipe << 1) | MEM_LATENCY'(issue);
      bus.mem_en_out <= issue;
      bus.valid_out <= pipe[MEM_LATENCY-1];
      if (pipe[MEM_LATENCY-1]) bus.vertex_out <= bus.vertex_data_in;
      if (state != IDLE) completed <= completed_nxt;
      case (state)
        IDLE: if (bus.start_in) begin
          mat <= bus.matrix_in;
          base <= bus.base_addr_in;
          count <= bus.count_in;
          bus.col_out <= bus.matrix_in[0];
          bus.col_set_out <= 1'b1;
          bus.busy_out <= 1'b1;
          col_idx <= '0;
          issued <= '0;
          completed <= '0;
          state <= LOAD;
        end
        LOAD: if (col_idx == 2'd3) begin
          bus.col_set_out <= 1'b0;
          bus.mem_addr_out <= base;
          issued <= COUNT_WIDTH'(1);
          bus.done_out <= count == '0;
          bus.busy_out <= count != '0;
          state <= count == '0 ? IDLE : FETCH;
        end else begin
          col_idx <= col_idx + 2'd1;
          bus.col_out <= mat[col_idx + 2'd1];
        end
        FETCH: if (issued == count) state <= DRAIN;
        else begin
          bus.mem_addr_out <= bus.mem_addr_out + ADDR_WIDTH'(1);
          issued <= issued + COUNT_WIDTH'(1);
        end
        default: if (completed_nxt == count) begin
          bus.done_out <= 1'b1;
          bus.busy_out <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
